// File: rtl/core_pkg.sv
// Shared core types and defaults.
// Fetch entries travel from fetch to decode in this format.
package core_pkg;

  localparam int CORE_XLEN = 32;
  localparam int CORE_ILEN = 32;
  localparam logic [CORE_XLEN-1:0] CORE_RESET_PC = '0;
  localparam logic [CORE_XLEN-1:0] CORE_PC_STEP = 32'd4;

  typedef struct packed {
    logic [CORE_XLEN-1:0] pc;
    logic [CORE_ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of fetched instructions.
// Flush wins over push and pop in the same cycle.
module fetch_buf
  import core_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic         head_q, head_d;
  logic [1:0]   count_q, count_d;
  logic         tail;

  // Next-state for storage, head pointer and occupancy.
  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    head_d   = head_q;
    count_d  = count_q;
    tail     = head_q ^ count_q[0];
    if (flush) begin
      head_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (push) begin
        mem_d[tail] = push_data;
      end
      head_d  = head_q ^ pop;
      count_d = count_q + 2'(push) - 2'(pop);
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      head_q   <= head_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[head_q];

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(push && !flush && count_q == 2'd2)
  );

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, 1-cycle imem, 2-entry out buffer.
// Credit-based issue keeps the buffer from ever overflowing.
module fetch_unit
  import core_pkg::*;
#(
  parameter int              XLEN     = CORE_XLEN,
  parameter int              ILEN     = CORE_ILEN,
  parameter logic [XLEN-1:0] RESET_PC = CORE_RESET_PC,
  parameter logic [XLEN-1:0] PC_STEP  = CORE_PC_STEP
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            inflight_q, inflight_d;
  logic            kill_q, kill_d;
  logic [1:0]      count;
  fetch_entry_t    head;
  fetch_entry_t    wr;
  logic            pop, push, req;
  logic [2:0]      occ;

  fetch_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (wr),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

  // Handshake, issue credit and output view of the buffer head.
  always_comb begin
    out_valid = (count != 2'd0) & ~redirect_valid;
    pop       = out_valid & out_ready;
    occ       = {1'b0, count} + {2'b0, inflight_q};
    req       = ~rst & ~redirect_valid
              & (occ < (3'd2 + {2'b0, pop}));
    push      = inflight_q & ~kill_q;
    wr.pc     = ipc_q;
    wr.instr  = imem_rdata;
    imem_req  = req;
    imem_addr = pc_q;
    out_pc    = (count != 2'd0) ? head.pc : '0;
    out_instr = (count != 2'd0) ? head.instr : '0;
  end

  // Next PC, in-flight tracking and response kill.
  always_comb begin
    pc_d       = pc_q;
    ipc_d      = ipc_q;
    inflight_d = req;
    kill_d     = 1'b0;
    if (redirect_valid) begin
      pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
      kill_d = inflight_q;
    end else if (req) begin
      pc_d  = pc_q + PC_STEP;
      ipc_d = pc_q;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      ipc_q      <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ipc_q      <= ipc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the core: it owns the program counter and issues one word-aligned read per cycle to a synchronous instruction memory with fixed 1-cycle latency. Returned instructions and their PCs go into a 2-entry output buffer and are handed to decode over a valid/ready handshake. A redirect input from execute (branch/jump) restarts fetch at a new PC and discards everything fetched but not yet consumed.

## Interface
- XLEN, 32, width of PC and memory address
- ILEN, 32, instruction width
- RESET_PC, 0, first fetch address after reset
- PC_STEP, 4, PC increment per fetch (byte address)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  read request this cycle
- imem_addr  out  XLEN  read address, valid when imem_req
- imem_rdata  in  ILEN  read data, valid exactly one cycle after an accepted imem_req
- redirect_valid  in  1  restart fetch at redirect_pc
- redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored (forced to 0)
- out_valid  out  1  out_instr/out_pc hold a valid instruction
- out_ready  in  1  decode accepts this cycle
- out_pc  out  XLEN  address of out_instr
- out_instr  out  ILEN  fetched instruction

## Operation
- State: pc, inflight (1 bit, with inflight_pc), kill (1 bit), 2-entry buffer (count 0..2, head pointer).
- Reset: pc = RESET_PC, inflight = 0, kill = 0, count = 0; imem_req = 0, out_valid = 0, out_pc = 0, out_instr = 0 while rst is high.
- pop = out_valid & out_ready.
- Issue rule: imem_req = !rst & !redirect_valid & (count + inflight - pop < 2). On issue: imem_addr = pc, pc <= pc + PC_STEP (modulo 2^XLEN, wraps silently), inflight <= 1, inflight_pc <= pc. Otherwise inflight <= 0.
- Response: when inflight = 1 and kill = 0, {inflight_pc, imem_rdata} is written at the buffer tail at that edge. The credit rule guarantees the buffer is never full on a write; a write into a full buffer is an assertion failure.
- Simultaneous push and pop: count unchanged, both take effect.
- out_valid = (count != 0) & !redirect_valid; out_pc/out_instr = head entry, 0 when count = 0.
- Redirect (priority over everything): pc <= {redirect_pc[XLEN-1:2], 2'b00}, count <= 0, no issue, no pop. If inflight = 1, kill <= 1 and that response is dropped on the following edge. Issue resumes the cycle after redirect_valid deasserts. Back-to-back redirects: the last one wins.
- No FSM beyond the counters; rst mid-operation drops everything immediately (async), including any in-flight response.

## Timing
- Fetch latency: imem_req at addr A in cycle N -> rdata in N+1 -> out_valid with out_pc = A in N+2.
- Throughput: 1 instruction/cycle sustained while out_ready = 1.
- Stall: with out_ready = 0, at most 2 more requests issue, then imem_req holds 0 and pc holds.
- Redirect at cycle R: out_valid = 0 in R; first request to the new PC in R+1; its out_valid in R+3.
- First request after rst deasserts: the first cycle with rst low.

## Structure
- Shared package core_pkg: XLEN, ILEN, RESET_PC defaults, and a typedef fetch_entry_t {pc, instr} used here and by decode.
- One sub-module, fetch_buf: 2-entry FIFO of fetch_entry_t with push, pop, flush, count and head outputs. The PC, inflight and kill flags stay in fetch_unit.

## Test plan
- Reset, out_ready = 1, memory returns addr ^ 32'hA5A5_0000 -> imem_addr sequence 0, 4, 8, … one per cycle; the first out_valid arrives 2 cycles after the first req with out_pc = 0, then one instruction per cycle in order.
- out_ready = 0 from cycle 3 for 10 cycles -> exactly 2 entries buffered, imem_req = 0 and pc frozen; on release, resumes with no lost or duplicated PC.
- redirect_valid for one cycle with redirect_pc = 32'h100 while 2 entries are buffered and 1 request is in flight -> out_valid = 0 that cycle; the in-flight response is dropped; next req is at 0x100; the next out_pc is 0x100.
- redirect_pc = 32'h203 -> fetch restarts at 0x200; two consecutive redirects to 0x40 then 0x80 -> the first delivered out_pc is 0x80.
- RESET_PC = 32'hFFFF_FFF8 -> PCs FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
- rst asserted mid-stream with a request in flight -> outputs go to 0 asynchronously; after release, the first out_pc is RESET_PC and no stale instruction appears.
